// File: rtl/aes_pkg.sv
// AES byte tables and word helpers, shared by the forward and inverse key schedules.
package aes_pkg;

    typedef logic [31:0] word_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Valid entries are 1..10; padded to 16 so a 4-bit round index never leaves the table.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic word_t sub_word(input word_t w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/inv_key_step.sv
// One backward step of the AES-128 key schedule: round key r -> round key r-1.
module inv_key_step
    import aes_pkg::*;
(
    input  logic [127:0] round_key,
    input  logic [7:0]   rcon,
    output logic [127:0] prev_key
);

    word_t w0, w1, w2, w3;
    word_t p0, p1, p2, p3;

    assign {w0, w1, w2, w3} = round_key;

    // Undo the forward chain from the last word back; p3 is the previous group's last word.
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;
    assign p0 = w0 ^ sub_word(rot_word(p3)) ^ {rcon, 24'h0};

    assign prev_key = {p0, p1, p2, p3};

endmodule

// File: rtl/inv_key_expansion.sv
// Streams AES-128 round keys 10..0 from the round-10 key, one inverse step per accepted beat.
module inv_key_expansion
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         rk_last
);

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    logic         fsm_q;
    logic [127:0] state_q;
    logic [3:0]   round_q;
    logic [127:0] prev_key;
    logic         beat;

    inv_key_step u_step (
        .round_key (state_q),
        .rcon      (RCON[round_q]),
        .prev_key  (prev_key)
    );

    assign key_ready = (fsm_q == IDLE);
    assign rk_valid  = (fsm_q == RUN);
    assign beat      = rk_valid && rk_ready;
    assign rk_data   = state_q;
    assign rk_round  = round_q;
    assign rk_last   = rk_valid && (round_q == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
        end else if (fsm_q == IDLE) begin
            if (key_valid) begin
                fsm_q   <= RUN;
                state_q <= key_in;
                round_q <= 4'd10;
            end
        end else if (beat) begin
            // Round 0 is the final key: leave it on rk_data and stop instead of stepping further.
            if (round_q == 4'd0) begin
                fsm_q <= IDLE;
            end else begin
                state_q <= prev_key;
                round_q <= round_q - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_inv_key_expansion.sv
// Self-checking bench: forward-expansion reference model (own GF(2^8) S-box) vs. the inverse stream.
module tb_inv_key_expansion;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] key_in = '0;
    logic         rk_valid;
    logic         rk_ready = 1'b1;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         rk_last;

    inv_key_expansion dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data), .rk_round(rk_round),
        .rk_last(rk_last)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] next_keys [11];   // keys of the stream about to be offered, indexed by round
    logic [127:0] exp_keys [11];    // keys of the stream the model believes is running
    bit           busy = 1'b0;
    int           exp_round = 0;
    bit           after_rst = 1'b1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return 8'(d >> (8 - n));
    endfunction

    function automatic logic [31:0] sw(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    // Forward AES-128 expansion; rk[r] = words 4r..4r+3.
    task automatic expand(input logic [127:0] cipher);
        logic [31:0] w [44];
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = cipher[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            if (i % 4 == 0) begin
                w[i] = w[i-4] ^ sw({w[i-1][23:0], w[i-1][31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else begin
                w[i] = w[i-4] ^ w[i-1];
            end
        end
        for (int r = 0; r < 11; r++) next_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic set_key(input logic [127:0] cipher);
        expand(cipher);
        key_in = next_keys[10];
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Compare process: outputs are stable at the falling edge; the model advances on what the rising edge will see.
    always @(negedge clk) begin
        if (after_rst) begin
            chk("rst_key_ready", 128'(key_ready), 128'(1'b1));
            chk("rst_rk_valid",  128'(rk_valid),  128'(1'b0));
            chk("rst_rk_data",   rk_data,         128'h0);
            chk("rst_rk_round",  128'(rk_round),  128'(4'd0));
            chk("rst_rk_last",   128'(rk_last),   128'(1'b0));
        end else begin
            chk("key_ready", 128'(key_ready), 128'(!busy));
            chk("rk_valid",  128'(rk_valid),  128'(busy));
            if (busy) begin
                chk("rk_data",  rk_data,         exp_keys[exp_round]);
                chk("rk_round", 128'(rk_round),  128'(exp_round));
                chk("rk_last",  128'(rk_last),   128'(exp_round == 0));
            end
        end
        after_rst = rst;
        if (rst) begin
            busy = 1'b0;
        end else if (busy) begin
            if (rk_ready) begin
                if (exp_round == 0) busy = 1'b0;
                else exp_round--;
            end
        end else if (key_valid) begin
            exp_keys  = next_keys;
            exp_round = 10;
            busy      = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_key();
        int  n = 0;
        bit  ok;
        key_valid = 1'b1;
        do begin
            ok = key_ready;
            step();
            n++;
        end while (!ok && n < 50);
        key_valid = 1'b0;
        chk("accept_in_time", 128'(ok), 128'(1'b1));
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < 300) begin
            rk_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            done = rk_valid && rk_ready && rk_last;
            step();
            n++;
        end
        rk_ready = 1'b1;
        chk("stream_done_in_time", 128'(done), 128'(1'b1));
    endtask

    task automatic wait_round(input int r);
        int n = 0;
        while (!(rk_valid && rk_round == 4'(r)) && n < 50) begin
            step();
            n++;
        end
        chk("reach_round", 128'(rk_round), 128'(r));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 2000000", $time);
        $fatal(1);
    end

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        repeat (2) step();
        rst = 1'b0;
        step();

        // FIPS-197 A.1 with the model itself pinned to known values
        set_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("model_rk10", next_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("model_rk1",  next_keys[1],  128'ha0fafe1788542cb123a339392a6c7605);
        send_key();
        for (int b = 1; b <= 11; b++) begin
            @(negedge clk);
            if (b == 1) begin
                chk("fips_beat1", rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
                chk("fips_beat1_round", 128'(rk_round), 128'(4'd10));
            end
            if (b == 2) begin
                chk("fips_beat2", rk_data, 128'hac7766f319fadc2128d12941575c006e);
                chk("fips_beat2_round", 128'(rk_round), 128'(4'd9));
            end
            if (b == 10) chk("fips_beat10", rk_data, 128'ha0fafe1788542cb123a339392a6c7605);
            if (b == 11) begin
                chk("fips_beat11", rk_data, 128'h2b7e151628aed2a6abf7158809cf4f3c);
                chk("fips_beat11_last", 128'(rk_last), 128'(1'b1));
            end
        end
        step();
        chk("fips_idle_after", 128'(key_ready), 128'(1'b1));

        // Backpressure at round 5
        set_key(rand128());
        send_key();
        wait_round(5);
        rk_ready = 1'b0;
        repeat (3) begin
            step();
            chk("stall_data",  rk_data,        next_keys[5]);
            chk("stall_round", 128'(rk_round), 128'(4'd5));
        end
        rk_ready = 1'b1;
        drain(1'b0);

        // Ignored key_valid mid-stream, then a key held across the final beat
        set_key(rand128());
        send_key();
        wait_round(7);
        key_in    = rand128();
        key_valid = 1'b1;
        chk("ignored_key_ready", 128'(key_ready), 128'(1'b0));
        step();
        key_valid = 1'b0;
        wait_round(3);
        set_key(rand128());
        key_valid = 1'b1;
        wait_round(0);
        step();
        chk("held_ready_after_last", 128'(key_ready), 128'(1'b1));
        chk("held_idle_valid",       128'(rk_valid),  128'(1'b0));
        step();
        key_valid = 1'b0;
        chk("held_accepted_valid", 128'(rk_valid), 128'(1'b1));
        chk("held_accepted_round", 128'(rk_round), 128'(4'd10));
        chk("held_accepted_data",  rk_data,        next_keys[10]);
        drain(1'b0);

        // Reset mid-run at round 6
        set_key(rand128());
        send_key();
        wait_round(6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_rk_valid",  128'(rk_valid),  128'(1'b0));
        chk("midrst_key_ready", 128'(key_ready), 128'(1'b1));
        set_key(rand128());
        send_key();
        chk("restart_round", 128'(rk_round), 128'(4'd10));
        drain(1'b0);

        // Random keys with random consumer stalls
        for (int k = 0; k < 1000; k++) begin
            set_key(rand128());
            send_key();
            drain(1'b1);
        end

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
